// File: rtl/seg_scan_capture.sv
// seg_scan_capture
//   Reader end of a multiplexed 4-digit, active-low 7-segment display bus.
//   All four inputs pass through one register stage before use. Each digit
//   slot is captured once its select, segment and decimal-point lines have
//   held the same value for STABLE_CYCLES consecutive samples. The segment
//   pattern is then decoded back to a hex nibble and the slot is marked in a
//   capture mask. When all four slots have been captured, the shadow values
//   are published together with a one-cycle Frame_Valid pulse.
//
//   Optional feature (macro SSC_TIMEOUT_EN): a stall watchdog. If no slot
//   is captured for TIMEOUT_CYCLES cycles, Scan_Stall is set and the partial
//   frame is dropped.
//
// Ports
//   Clk          system clock, rising edge
//   Reset_n      synchronous active-low reset
//   Dig_n[3:0]   digit selects, active-low, bit0 = D1 .. bit3 = D4
//   Seg_n[6:0]   segments, active-low, bit0 = A .. bit6 = G
//   Dp_n         decimal point, active-low
//   Clr          one-cycle pulse that clears the sticky error flags
//   Digits[15:0] last complete frame, [3:0] = D1 .. [15:12] = D4
//   Known[3:0]   per digit, 1 = pattern was a valid hex glyph
//   Dp[3:0]      per digit decimal point, active-high
//   Frame_Valid  one-cycle pulse when Digits/Known/Dp update
//   Scan_Stall   sticky stall flag (only with SSC_TIMEOUT_EN)
//   Err_Multi    sticky: more than one digit select was low in one sample
module seg_scan_capture #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [3:0]  Dig_n,
  input  logic [6:0]  Seg_n,
  input  logic        Dp_n,
  input  logic        Clr,
  output logic [15:0] Digits,
  output logic [3:0]  Known,
  output logic [3:0]  Dp,
  output logic        Frame_Valid,
`ifdef SSC_TIMEOUT_EN
  output logic        Scan_Stall,
`endif
  output logic        Err_Multi
);

  if (STABLE_CYCLES < 1 || STABLE_CYCLES > 255) begin : g_bad_stable
    $error("seg_scan_capture: STABLE_CYCLES must be in 1..255");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("seg_scan_capture: TIMEOUT_CYCLES must be at least 2");
  end

  localparam logic [7:0] STABLE_L = 8'(STABLE_CYCLES);

  typedef enum logic [1:0] {IDLE, TRACK, HELD} state_t;

  // Active-high pattern {G..A} -> {known, nibble}. Unrecognised patterns,
  // blank included, decode to nibble 0 with known cleared.
  function automatic logic [4:0] decode(input logic [6:0] pat);
    case (pat)
      7'h3F:   decode = 5'h10;
      7'h06:   decode = 5'h11;
      7'h5B:   decode = 5'h12;
      7'h4F:   decode = 5'h13;
      7'h66:   decode = 5'h14;
      7'h6D:   decode = 5'h15;
      7'h7D:   decode = 5'h16;
      7'h07:   decode = 5'h17;
      7'h7F:   decode = 5'h18;
      7'h6F:   decode = 5'h19;
      7'h77:   decode = 5'h1A;
      7'h7C:   decode = 5'h1B;
      7'h39:   decode = 5'h1C;
      7'h5E:   decode = 5'h1D;
      7'h79:   decode = 5'h1E;
      7'h71:   decode = 5'h1F;
      default: decode = 5'h00;
    endcase
  endfunction

  // Input sample stage
  logic [3:0] dig_q;
  logic [6:0] seg_q;
  logic       dp_q;
  logic       clr_q;

  // Tracker state: the sample currently being timed
  state_t     state;
  logic [7:0] cnt;
  logic [3:0] dig_l;
  logic [6:0] seg_l;
  logic       dp_l;

  // Frame assembly
  logic [3:0] mask;
  logic [3:0] sh_nib [4];
  logic [3:0] sh_known;
  logic [3:0] sh_dp;

  // Per-sample decisions
  logic [2:0] nlow;
  logic       onehot;
  logic       multi;
  logic       same;
  logic       start;
  logic       capture;
  logic [1:0] cap_idx;
  logic [3:0] cap_bit;
  logic [3:0] dec_nib;
  logic       dec_known;

  // NOTE: every signal gets a default before any conditional assignment, so
  // no path leaves one unassigned and no latch is inferred.
  always_comb begin
    nlow    = 3'd0;
    cap_idx = 2'd0;
    for (int k = 0; k < 4; k++) begin
      nlow = nlow + {2'b00, ~dig_q[k]};
      if (!dig_q[k]) cap_idx = 2'(k);
    end
    onehot  = (nlow == 3'd1);
    multi   = (nlow > 3'd1);
    cap_bit = ~dig_q;
    same    = (dig_q == dig_l) && (seg_q == seg_l) && (dp_q == dp_l);
    // A new slot starts timing when the tracker was idle or the lines moved.
    start   = onehot && (state == IDLE || !same);
    // The first sample already counts as one, so STABLE_CYCLES=1 captures
    // on the start cycle itself.
    capture = (start && STABLE_L == 8'd1) ||
              (onehot && same && state == TRACK && (cnt + 8'd1) == STABLE_L);
    {dec_known, dec_nib} = decode(~seg_q);
  end

`ifdef SSC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] tcnt;
  logic          stall_hit;
  assign stall_hit = !capture && (tcnt == TW'(TIMEOUT_CYCLES - 1));
`endif

  // NOTE: the shadow slots have no reset; the capture mask guarantees each
  // one is rewritten before it is ever published.
  always_ff @(posedge Clk) begin
    if (capture) begin
      sh_nib[cap_idx]   <= dec_nib;
      sh_known[cap_idx] <= dec_known;
      sh_dp[cap_idx]    <= ~dp_q;
    end
  end

  // NOTE: all state here uses non-blocking <=, so every decision below sees
  // the values from before this edge; blocking = would leak updates forward.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      dig_q       <= 4'hF;
      seg_q       <= 7'h7F;
      dp_q        <= 1'b1;
      clr_q       <= 1'b0;
      state       <= IDLE;
      cnt         <= 8'd0;
      dig_l       <= 4'hF;
      seg_l       <= 7'h7F;
      dp_l        <= 1'b1;
      mask        <= 4'h0;
      Digits      <= 16'h0000;
      Known       <= 4'h0;
      Dp          <= 4'h0;
      Frame_Valid <= 1'b0;
      Err_Multi   <= 1'b0;
`ifdef SSC_TIMEOUT_EN
      tcnt        <= '0;
      Scan_Stall  <= 1'b0;
`endif
    end else begin
      dig_q       <= Dig_n;
      seg_q       <= Seg_n;
      dp_q        <= Dp_n;
      clr_q       <= Clr;
      Frame_Valid <= 1'b0;

      // A same-cycle set wins over Clr.
      if (multi)      Err_Multi <= 1'b1;
      else if (clr_q) Err_Multi <= 1'b0;

      // Tracker
      if (!onehot) begin
        state <= IDLE;
      end else if (start) begin
        dig_l <= dig_q;
        seg_l <= seg_q;
        dp_l  <= dp_q;
        cnt   <= 8'd1;
        state <= capture ? HELD : TRACK;
      end else if (state == TRACK) begin
        cnt <= cnt + 8'd1;
        if (capture) state <= HELD;
      end

      // A full mask is published one cycle after the capture that filled
      // it; a capture landing on that same cycle opens the next frame.
      if (mask == 4'hF) begin
        Digits      <= {sh_nib[3], sh_nib[2], sh_nib[1], sh_nib[0]};
        Known       <= sh_known;
        Dp          <= sh_dp;
        Frame_Valid <= 1'b1;
        mask        <= capture ? cap_bit : 4'h0;
      end else if (capture) begin
        mask <= mask | cap_bit;
      end
`ifdef SSC_TIMEOUT_EN
      else if (stall_hit) begin
        mask <= 4'h0;
      end

      if (capture)        tcnt <= '0;
      else if (stall_hit) tcnt <= '0;
      else                tcnt <= tcnt + 1'b1;

      if (stall_hit)  Scan_Stall <= 1'b1;
      else if (clr_q) Scan_Stall <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Randomised scoreboard bench for seg_scan_capture. A reference model works
// directly from the display-bus rules: run length of identical samples,
// slot capture when a single-select sample has been seen STABLE_CYCLES
// times in a row, frame complete when all four slots are captured. Expected
// frames go into a queue tagged with the clock edge they are due on; a
// separate monitor pops them when Frame_Valid is seen.
module tb_seg_scan_capture;
  localparam int S = 4;
`ifdef SSC_TIMEOUT_EN
  localparam int T = 16;
`else
  localparam int T = 1024;
`endif
  localparam int NMAX = 8192;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  dig_n = 4'hF;
  logic [6:0]  seg_n = 7'h7F;
  logic        dp_n = 1'b1;
  logic        clr = 1'b0;
  logic [15:0] digits;
  logic [3:0]  known;
  logic [3:0]  dp;
  logic        frame_valid;
  logic        err_multi;
`ifdef SSC_TIMEOUT_EN
  logic        scan_stall;
`endif

  seg_scan_capture #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .Clk(clk), .Reset_n(rst_n), .Dig_n(dig_n), .Seg_n(seg_n), .Dp_n(dp_n),
    .Clr(clr), .Digits(digits), .Known(known), .Dp(dp),
    .Frame_Valid(frame_valid),
`ifdef SSC_TIMEOUT_EN
    .Scan_Stall(scan_stall),
`endif
    .Err_Multi(err_multi)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model
  typedef struct {
    int          edge_no;
    logic [15:0] digits;
    logic [3:0]  known;
    logic [3:0]  dp;
  } exp_t;
  exp_t exp_q[$];

  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  bit         err_after [NMAX];
  bit         stall_after [NMAX];
  logic [11:0] prev;
  bit          have_prev = 1'b0;
  int          run = 0;
  logic [3:0]  m_mask = 4'h0;
  logic [3:0]  m_nib [4];
  logic [3:0]  m_known;
  logic [3:0]  m_dp;
  int          base = 0;

  // Drive one sample (seen by the DUT at edge n), update the model, then
  // wait for the following falling edge.
  task automatic step(input logic r, input logic [3:0] d, input logic [6:0] pat,
                      input logic p, input logic c);
    int n;
    int nlow;
    int slot;
    bit cap;
    bit fire;
    logic [11:0] cur;
    rst_n = r; dig_n = d; seg_n = ~pat; dp_n = p; clr = c;
    n = cyc + 1;
    if (n < NMAX - 2) begin
      if (!r) begin
        have_prev = 1'b0; run = 0; m_mask = 4'h0; base = n;
        err_after[n] = 1'b0; err_after[n+1] = 1'b0;
        stall_after[n] = 1'b0; stall_after[n+1] = 1'b0;
      end else begin
        cur = {d, ~pat, p};
        if (have_prev && cur == prev) run++;
        else run = 1;
        prev = cur; have_prev = 1'b1;
        nlow = 0; slot = 0;
        for (int k = 0; k < 4; k++) if (!d[k]) begin nlow++; slot = k; end
        cap = (nlow == 1) && (run == S);
        err_after[n+1] = (nlow > 1) ? 1'b1 : (c ? 1'b0 : err_after[n]);
        if (cap) begin
          m_nib[slot] = 4'h0; m_known[slot] = 1'b0;
          for (int g = 0; g < 16; g++)
            if (glyph[g] == pat) begin m_nib[slot] = 4'(g); m_known[slot] = 1'b1; end
          m_dp[slot] = ~p;
          m_mask[slot] = 1'b1;
          if (m_mask == 4'hF) begin
            exp_q.push_back('{n + 2, {m_nib[3], m_nib[2], m_nib[1], m_nib[0]}, m_known, m_dp});
            m_mask = 4'h0;
          end
        end
        fire = 1'b0;
`ifdef SSC_TIMEOUT_EN
        if (cap) base = n + 1;
        else if (n + 1 - base == T) begin fire = 1'b1; base = n + 1; m_mask = 4'h0; end
`endif
        stall_after[n+1] = fire ? 1'b1 : (c ? 1'b0 : stall_after[n]);
      end
    end
    @(negedge clk);
  endtask

  task automatic hold(input logic [3:0] d, input logic [6:0] pat, input logic p, input int len);
    for (int i = 0; i < len; i++) step(1'b1, d, pat, p, 1'b0);
  endtask

  task automatic scan4(input logic [6:0] p1, input logic [6:0] p2, input logic [6:0] p3,
                       input logic [6:0] p4, input logic [3:0] dpn, input int len);
    hold(4'b1110, p1, dpn[0], len);
    hold(4'b1101, p2, dpn[1], len);
    hold(4'b1011, p3, dpn[2], len);
    hold(4'b0111, p4, dpn[3], len);
    hold(4'b1111, 7'h00, 1'b1, 4);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (cyc >= 1 && cyc < NMAX) begin
      check("err_multi", {31'd0, err_multi}, {31'd0, err_after[cyc]});
`ifdef SSC_TIMEOUT_EN
      check("scan_stall", {31'd0, scan_stall}, {31'd0, stall_after[cyc]});
`endif
      if (exp_q.size() > 0 && exp_q[0].edge_no == cyc) begin
        check("frame_valid", {31'd0, frame_valid}, 32'd1);
        check("frame_digits", {16'd0, digits}, {16'd0, exp_q[0].digits});
        check("frame_known", {28'd0, known}, {28'd0, exp_q[0].known});
        check("frame_dp", {28'd0, dp}, {28'd0, exp_q[0].dp});
        void'(exp_q.pop_front());
      end else if (frame_valid) begin
        check("frame_valid_unexpected", {31'd0, frame_valid}, 32'd0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int len;
    logic [3:0] d;
    logic [6:0] pat;

    // Reset with random inputs
    for (int i = 0; i < 2; i++)
      step(1'b0, 4'($urandom), 7'($urandom), 1'($urandom), 1'($urandom));
    check("reset_digits", {16'd0, digits}, 32'd0);
    check("reset_known", {28'd0, known}, 32'd0);
    check("reset_dp", {28'd0, dp}, 32'd0);
    check("reset_fv", {31'd0, frame_valid}, 32'd0);
    check("reset_err", {31'd0, err_multi}, 32'd0);
    hold(4'hF, 7'h00, 1'b1, 2);

    // Clean scan: 1, 2, A, F
    scan4(7'h06, 7'h5B, 7'h77, 7'h71, 4'hF, 8);
    check("clean_digits", {16'd0, digits}, 32'h0000FA21);
    check("clean_known", {28'd0, known}, 32'hF);
    check("clean_dp", {28'd0, dp}, 32'h0);

    // Glitch on D1: 06 for 3 samples, then 5B long enough to capture
    hold(4'b1110, 7'h06, 1'b1, 3);
    hold(4'b1110, 7'h5B, 1'b1, 6);
    hold(4'b1101, 7'h3F, 1'b1, 8);
    hold(4'b1011, 7'h06, 1'b1, 8);
    hold(4'b0111, 7'h07, 1'b1, 8);
    hold(4'hF, 7'h00, 1'b1, 4);
    check("glitch_digits", {16'd0, digits}, 32'h00007102);

    // Unknown and blank glyphs, decimal point on D4
    scan4(7'h3F, 7'h49, 7'h00, 7'h06, 4'b0111, 8);
    check("unknown_digits", {16'd0, digits}, 32'h00001000);
    check("unknown_known", {28'd0, known}, 32'h9);
    check("unknown_dp", {28'd0, dp}, 32'h8);

    // Multi-select, sticky through a clean frame, then cleared
    step(1'b1, 4'b1100, 7'h06, 1'b1, 1'b0);
    scan4(7'h4F, 7'h66, 7'h6D, 7'h7D, 4'hF, 8);
    check("multi_sticky", {31'd0, err_multi}, 32'd1);
    check("multi_frame_digits", {16'd0, digits}, 32'h00006543);
    step(1'b1, 4'hF, 7'h00, 1'b1, 1'b1);
    hold(4'hF, 7'h00, 1'b1, 3);
    check("multi_cleared", {31'd0, err_multi}, 32'd0);

`ifdef SSC_TIMEOUT_EN
    // Partial frame then a long gap
    hold(4'b1110, 7'h3F, 1'b1, 8);
    hold(4'b1101, 7'h06, 1'b1, 8);
    hold(4'hF, 7'h00, 1'b1, 20);
    check("stall_set", {31'd0, scan_stall}, 32'd1);
    check("stall_digits_kept", {16'd0, digits}, 32'h00006543);
    scan4(7'h7F, 7'h6F, 7'h7C, 7'h5E, 4'hF, 8);
    check("stall_new_frame", {16'd0, digits}, 32'h0000DB98);
    step(1'b1, 4'hF, 7'h00, 1'b1, 1'b1);
    hold(4'hF, 7'h00, 1'b1, 2);
    check("stall_cleared", {31'd0, scan_stall}, 32'd0);
`endif

    // Random scanning with glitches, blanks, multi-selects and clears
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 19);
      if (r < 15)      d = ~(4'b0001 << $urandom_range(0, 3));
      else if (r < 17) d = 4'hF;
      else             d = 4'($urandom);
      if ($urandom_range(0, 9) < 8) pat = glyph[$urandom_range(0, 15)];
      else                          pat = 7'($urandom);
      len = $urandom_range(1, 10);
      step(1'b1, d, pat, 1'($urandom), ($urandom_range(0, 19) == 0));
      hold(d, pat, dp_n, len - 1);
    end
    hold(4'hF, 7'h00, 1'b1, 6);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
